song_sequencer: RTL and testbench

- Programmable auto-play sequencer, the parametrised successor of the fixed single-song auto-player.
- The song is a RAM of (note, duration) entries loaded at run time.
- Playback is paced by a one-cycle beat tick, with start/stop/pause, loop and staccato modes.
- Drives the note code to the tone generator and a one-hot note LED bar.

---
 rtl/song_sequencer.sv | 146 ++++++++++++++
 tb/tb_song_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: RAM-programmed auto-play note sequencer paced by a beat tick.
// Optional macro SONG_SEQ_TRANSPOSE_EN adds a signed transpose input, sampled at each entry start.
module song_sequencer #(
  parameter int NOTE_W    = 4,
  parameter int DUR_W     = 4,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int REST_CODE = 0,
  parameter int LED_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BEAT_TICK,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              staccato,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [DUR_W-1:0]  wr_dur,
`ifdef SONG_SEQ_TRANSPOSE_EN
  input  logic signed [3:0] transpose,
`endif
  output logic [NOTE_W-1:0] auto_note,
  output logic [LED_W-1:0]  Led,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W-1:0] position
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_CODE);
  state_t state_q, state_d;
  logic [NOTE_W-1:0] note_mem [DEPTH];
  logic [DUR_W-1:0]  dur_mem [DEPTH];
  logic [ADDR_W-1:0] pos_q, pos_d, nxt_pos, ld_addr;
  logic [DUR_W-1:0]  cnt_q, cnt_d, dur_q, dur_d, cnt_inc;
  logic [NOTE_W-1:0] note_q, note_d, auto_q, auto_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              done_q, done_d, song_end, load, clear;

  function automatic logic [NOTE_W-1:0] eff_note(input logic [NOTE_W-1:0] n);
`ifdef SONG_SEQ_TRANSPOSE_EN
    int v;
    v = int'(n) + int'(transpose);
    v = (v < 1) ? 1 : (v > (1 << NOTE_W) - 1) ? (1 << NOTE_W) - 1 : v;
    return (n == REST) ? REST : NOTE_W'(v);
`else
    return n;
`endif
  endfunction

  function automatic logic [LED_W-1:0] led_of(input logic [NOTE_W-1:0] n);
    logic [LED_W-1:0] l;
    l = '0;
    for (int k = 0; k < LED_W; k++) l[k] = (n != REST) && (int'(n) == k + 1);
    return l;
  endfunction

  assign auto_note = auto_q;
  assign Led       = led_q;
  assign playing   = state_q != IDLE;
  assign done      = done_q;
  assign position  = pos_q;

  // song RAM: writable only while idle, never cleared
  always_ff @(posedge CLK) begin
    if (wr_en && state_q == IDLE) begin
      note_mem[wr_addr] <= wr_note;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  // control: stop > start > pause > beat tick, then entry load / clear and output shaping
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    note_d  = note_q;
    done_d  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    ld_addr = '0;
    cnt_inc = cnt_q + 1'b1;
    nxt_pos = pos_q + 1'b1;
    song_end = (pos_q == ADDR_W'(DEPTH - 1)) || (dur_mem[nxt_pos] == '0);
    if (stop) clear = state_q != IDLE;
    else if (start) begin
      load   = dur_mem[0] != '0;
      clear  = dur_mem[0] == '0;
      done_d = dur_mem[0] == '0;
    end else if (state_q == PLAY && pause) state_d = PAUSE;
    else if (state_q == PAUSE) state_d = pause ? PAUSE : PLAY;
    else if (state_q == PLAY && BEAT_TICK) begin
      cnt_d = cnt_inc;
      if (cnt_inc == dur_q) begin
        load    = !song_end || loop_en;
        ld_addr = song_end ? '0 : nxt_pos;
        clear   = song_end && !loop_en;
        done_d  = song_end && !loop_en;
      end
    end
    if (load) begin
      state_d = PLAY;
      pos_d   = ld_addr;
      cnt_d   = '0;
      dur_d   = dur_mem[ld_addr];
      note_d  = eff_note(note_mem[ld_addr]);
    end
    if (clear) begin
      state_d = IDLE;
      pos_d   = '0;
      cnt_d   = '0;
      dur_d   = '0;
      note_d  = REST;
    end
    led_d  = (state_d == PAUSE) ? led_q : led_of(note_d);
    auto_d = (state_d == PAUSE) ? auto_q :
             (state_d == PLAY && staccato && dur_d >= DUR_W'(2) && cnt_d == dur_d - 1'b1) ? REST : note_d;
  end

  // state and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      dur_q   <= '0;
      note_q  <= REST;
      auto_q  <= REST;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
      auto_q  <= auto_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed checks of playback, staccato, loop, pause, stop and empty song.
module tb_song_sequencer;
  logic       CLK = 0, RESET = 1, BEAT_TICK = 0, start = 0, stop = 0, pause = 0;
  logic       loop_en = 0, staccato = 0, wr_en = 0;
  logic [5:0] wr_addr = 0;
  logic [3:0] wr_note = 0, wr_dur = 0;
  logic [3:0] auto_note;
  logic [7:0] Led;
  logic       playing, done;
  logic [5:0] position;
  int checks = 0, errors = 0;
`ifdef SONG_SEQ_TRANSPOSE_EN
  logic signed [3:0] transpose = 0;
`endif

  song_sequencer dut (
    .CLK(CLK), .RESET(RESET), .BEAT_TICK(BEAT_TICK), .start(start), .stop(stop),
    .pause(pause), .loop_en(loop_en), .staccato(staccato), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
`ifdef SONG_SEQ_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .auto_note(auto_note), .Led(Led), .playing(playing), .done(done), .position(position)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int n, input int d);
    wr_en = 1; wr_addr = 6'(a); wr_note = 4'(n); wr_dur = 4'(d);
    step();
    wr_en = 0;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; step(); stop = 0;
  endtask

  task automatic tick();
    step(3);
    BEAT_TICK = 1; step(); BEAT_TICK = 0;
  endtask

  initial begin
    step(2);
    RESET = 0;
    chk("rst_note", auto_note, 0);
    chk("rst_led", Led, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", position, 0);
    wr(0, 3, 2); wr(1, 4, 1); wr(2, 0, 0);
    pulse_start();
    chk("t1_play", playing, 1);
    chk("t1_note0", auto_note, 3);
    chk("t1_led0", Led, 8'b0000_0100);
    tick();
    chk("t1_beat1", auto_note, 3);
    chk("t1_pos1", position, 0);
    tick();
    chk("t1_beat3", auto_note, 4);
    chk("t1_led3", Led, 8'b0000_1000);
    chk("t1_pos3", position, 1);
    chk("t1_nodone", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_end_note", auto_note, 0);
    chk("t1_end_led", Led, 0);
    chk("t1_end_play", playing, 0);
    step();
    chk("t1_done_1cyc", done, 0);
    staccato = 1;
    pulse_start();
    chk("t2_b1", auto_note, 3);
    tick();
    chk("t2_b2_rest", auto_note, 0);
    chk("t2_b2_led", Led, 8'b0000_0100);
    tick();
    chk("t2_b3", auto_note, 4);
    tick();
    chk("t2_done", done, 1);
    staccato = 0;
    loop_en = 1;
    pulse_start();
    chk("t3_p0", position, 0);
    tick(); chk("t3_tk1", position, 0);
    tick(); chk("t3_tk2", position, 1);
    tick(); chk("t3_tk3", position, 0); chk("t3_tk3_play", playing, 1); chk("t3_tk3_done", done, 0);
    tick(); chk("t3_tk4", position, 0);
    tick(); chk("t3_tk5", position, 1); chk("t3_tk5_done", done, 0);
    tick(); chk("t3_tk6", position, 0); chk("t3_tk6_note", auto_note, 3);
    pulse_stop();
    chk("t3_stop_play", playing, 0);
    loop_en = 0;
    pulse_start();
    tick();
    pause = 1;
    step();
    chk("t4_paused_play", playing, 1);
    for (int i = 0; i < 10; i++) begin
      BEAT_TICK = (i == 3 || i == 7);
      step();
    end
    BEAT_TICK = 0;
    chk("t4_frozen_note", auto_note, 3);
    chk("t4_frozen_pos", position, 0);
    pause = 0;
    step();
    chk("t4_resume_note", auto_note, 3);
    tick();
    chk("t4_adv_note", auto_note, 4);
    chk("t4_adv_pos", position, 1);
    tick();
    chk("t4_done", done, 1);
    pulse_start();
    stop = 1; wr_en = 1; wr_addr = 1; wr_note = 7; wr_dur = 1;
    step();
    stop = 0; wr_en = 0;
    chk("t5_stop_play", playing, 0);
    chk("t5_stop_note", auto_note, 0);
    chk("t5_stop_done", done, 0);
    pulse_start();
    tick(); tick();
    chk("t5_ignored_wr", auto_note, 4);
    pulse_stop();
    wr(1, 7, 1);
    pulse_start();
    tick(); tick();
    chk("t5_landed_wr", auto_note, 7);
    chk("t5_landed_led", Led, 8'b0100_0000);
    pulse_stop();
`ifdef SONG_SEQ_TRANSPOSE_EN
    wr(0, 14, 1);
    transpose = 2;
    pulse_start();
    chk("tx_sat", auto_note, 15);
    chk("tx_led", Led, 0);
    pulse_stop();
    transpose = 0;
`endif
    wr(0, 3, 0);
    pulse_start();
    chk("t6_empty_done", done, 1);
    chk("t6_empty_play", playing, 0);
    step();
    chk("t6_empty_done_off", done, 0);
    chk("t6_empty_play2", playing, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
